// File: rtl/magic_dev_pkg.sv
// Shared types for the magic device read requester and its response FIFO.
// Entry layout is {timeout, select, data}, 77 bits.
package magic_dev_pkg;

    localparam int SELECT_W = 12;
    localparam int DATA_W   = 64;

    typedef struct packed {
        logic                timeout;
        logic [SELECT_W-1:0] select;
        logic [DATA_W-1:0]   data;
    } resp_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } req_state_e;

endpackage

// File: rtl/magic_dev_resp_fifo.sv
// Small register-based first-word-fall-through FIFO.
// The head is forced to zero while the FIFO is empty.
module magic_dev_resp_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [7:0],
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PTR_W-1:0] ptr_t;

    entry_t mem [DEPTH];
    ptr_t   wr_ptr;
    ptr_t   rd_ptr;
    logic   full;
    logic   do_push;
    logic   do_pop;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && valid;
    // A pop frees the slot this push needs, so a full FIFO can still take one.
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state is updated with <= so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the empty-gated head below keeps
    // stale contents invisible, so resetting it would only add reset fanout.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/magic_device_requester.sv
// Host-side master for the magic device read interface: one outstanding read,
// bounded by a timeout, with results queued in a small response FIFO.
module magic_device_requester
    import magic_dev_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RESP_DEPTH     = 2,
    parameter int STAT_W         = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SELECT_W-1:0] req_select,
    output logic [SELECT_W-1:0] read_select,
    output logic                read_ready,
    input  logic                read_valid,
    input  logic [DATA_W-1:0]   read_data,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic [SELECT_W-1:0] resp_select,
    output logic                resp_timeout,
    output logic [STAT_W-1:0]   timeout_count
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    req_state_e          state;
    req_state_e          state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_cnt_nxt;
    logic [SELECT_W-1:0] select_nxt;
    logic                timeout_inc;

    logic                fifo_push;
    resp_entry_t         fifo_push_data;
    resp_entry_t         fifo_head;
    logic [CNT_W-1:0]    fifo_count;

    // read_ready is a decode of the state register, so it is glitch-free and
    // rises the cycle after accept.
    assign read_ready = (state == WAIT);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        select_nxt     = read_select;
        timeout_inc    = 1'b0;
        fifo_push      = 1'b0;
        fifo_push_data = '0;
        req_ready      = 1'b0;

        case (state)
            IDLE: begin
                req_ready = (fifo_count < CNT_W'(RESP_DEPTH));
                if (req_valid && req_ready) begin
                    select_nxt   = req_select;
                    wait_cnt_nxt = '0;
                    state_nxt    = WAIT;
                end
            end
            WAIT: begin
                // Data arriving in the expiry cycle takes priority over timeout.
                if (read_valid) begin
                    fifo_push      = 1'b1;
                    fifo_push_data = '{timeout: 1'b0, select: read_select, data: read_data};
                    state_nxt      = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    fifo_push      = 1'b1;
                    fifo_push_data = '{timeout: 1'b1, select: read_select, data: '0};
                    timeout_inc    = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            read_select   <= '0;
            timeout_count <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            read_select <= select_nxt;
            if (timeout_inc && (timeout_count != '1)) begin
                timeout_count <= timeout_count + STAT_W'(1);
            end
        end
    end

    magic_dev_resp_fifo #(
        .DEPTH   (RESP_DEPTH),
        .entry_t (resp_entry_t)
    ) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (resp_ready),
        .head      (fifo_head),
        .valid     (resp_valid),
        .count     (fifo_count)
    );

    assign resp_data    = fifo_head.data;
    assign resp_select  = fifo_head.select;
    assign resp_timeout = fifo_head.timeout;

endmodule

// File: tb/tb_magic_device_requester.sv
// Directed self-checking bench for magic_device_requester with
// TIMEOUT_CYCLES=8 and RESP_DEPTH=2.
module tb_magic_device_requester;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_select;
    logic [11:0] read_select;
    logic        read_ready;
    logic        read_valid;
    logic [63:0] read_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [11:0] resp_select;
    logic        resp_timeout;
    logic [15:0] timeout_count;

    int checks = 0;
    int errors = 0;

    magic_device_requester #(
        .TIMEOUT_CYCLES (8),
        .RESP_DEPTH     (2),
        .STAT_W         (16)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_select    (req_select),
        .read_select   (read_select),
        .read_ready    (read_ready),
        .read_valid    (read_valid),
        .read_data     (read_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_select   (resp_select),
        .resp_timeout  (resp_timeout),
        .timeout_count (timeout_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a command and hold it until accepted (bounded).
    task automatic issue(input logic [11:0] sel);
        int n = 0;
        req_valid  = 1'b1;
        req_select = sel;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check("issue_accept", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
    endtask

    // Return one word from the device while read_ready is high (bounded).
    task automatic complete(input logic [63:0] data);
        int n = 0;
        while (!read_ready && n < 20) begin
            step();
            n++;
        end
        check("complete_ready", read_ready, 1'b1);
        read_valid = 1'b1;
        read_data  = data;
        step();
        read_valid = 1'b0;
        read_data  = '0;
    endtask

    task automatic pop_one();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_select = '0;
        read_valid = 1'b0;
        read_data  = '0;
        resp_ready = 1'b0;
        #23;

        // Reset values
        check("rst_read_ready", read_ready, 1'b0);
        check("rst_read_select", read_select, 12'h000);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_data", resp_data, 64'h0);
        check("rst_timeout_count", timeout_count, 16'd0);
        reset_n = 1'b1;
        step();
        check("idle_req_ready", req_ready, 1'b1);

        // Single read: three read_ready cycles, data on the third
        req_valid  = 1'b1;
        req_select = 12'h012;
        step();
        req_valid = 1'b0;
        check("single_rr_c1", read_ready, 1'b1);
        check("single_sel", read_select, 12'h012);
        check("single_req_ready_wait", req_ready, 1'b0);
        step();
        check("single_rr_c2", read_ready, 1'b1);
        step();
        check("single_rr_c3", read_ready, 1'b1);
        check("single_no_resp_yet", resp_valid, 1'b0);
        read_valid = 1'b1;
        read_data  = 64'hDEADBEEF_CAFEF00D;
        step();
        read_valid = 1'b0;
        check("single_rr_drop", read_ready, 1'b0);
        check("single_resp_valid", resp_valid, 1'b1);
        check("single_resp_data", resp_data, 64'hDEADBEEF_CAFEF00D);
        check("single_resp_select", resp_select, 12'h012);
        check("single_resp_timeout", resp_timeout, 1'b0);
        pop_one();
        check("single_popped", resp_valid, 1'b0);

        // Timeout: read_ready high exactly 8 cycles
        issue(12'h0A1);
        n = 0;
        while (read_ready && n < 20) begin
            n++;
            step();
        end
        check("to1_rr_cycles", 64'(n), 64'd8);
        check("to1_resp_valid", resp_valid, 1'b1);
        check("to1_resp_timeout", resp_timeout, 1'b1);
        check("to1_resp_data", resp_data, 64'h0);
        check("to1_resp_select", resp_select, 12'h0A1);
        check("to1_count", timeout_count, 16'd1);
        pop_one();
        issue(12'h0A2);
        n = 0;
        while (read_ready && n < 20) begin
            n++;
            step();
        end
        check("to2_rr_cycles", 64'(n), 64'd8);
        check("to2_count", timeout_count, 16'd2);
        pop_one();

        // Expiry race: data on the 8th wait cycle wins
        issue(12'h0B2);
        repeat (7) step();
        check("race_rr_last", read_ready, 1'b1);
        read_valid = 1'b1;
        read_data  = 64'h5;
        step();
        read_valid = 1'b0;
        check("race_rr_drop", read_ready, 1'b0);
        check("race_timeout", resp_timeout, 1'b0);
        check("race_data", resp_data, 64'h5);
        check("race_count", timeout_count, 16'd2);
        pop_one();

        // Spurious valid while idle
        read_valid = 1'b1;
        read_data  = 64'h1234;
        repeat (3) step();
        read_valid = 1'b0;
        check("spur_resp_valid", resp_valid, 1'b0);
        check("spur_read_ready", read_ready, 1'b0);

        // Backpressure: two responses fill the FIFO, third command stalls
        issue(12'h101);
        complete(64'h1111);
        issue(12'h102);
        complete(64'h2222);
        req_valid  = 1'b1;
        req_select = 12'h103;
        step();
        check("bp_req_ready", req_ready, 1'b0);
        step();
        check("bp_read_ready", read_ready, 1'b0);
        check("bp_head_hold", resp_select, 12'h101);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("bp_req_ready_after_pop", req_ready, 1'b1);
        check("bp_head2", resp_select, 12'h102);
        step();
        req_valid = 1'b0;
        check("bp_third_rr", read_ready, 1'b1);
        check("bp_third_sel", read_select, 12'h103);
        complete(64'h3333);
        check("bp_drain1_sel", resp_select, 12'h102);
        check("bp_drain1_data", resp_data, 64'h2222);
        pop_one();
        check("bp_drain2_sel", resp_select, 12'h103);
        check("bp_drain2_data", resp_data, 64'h3333);
        pop_one();
        check("bp_empty", resp_valid, 1'b0);

        // Reset mid-WAIT with one queued response and nonzero timeout count
        issue(12'h1C0);
        complete(64'hC0);
        issue(12'h1C3);
        step();
        check("rst_pre_rr", read_ready, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstw_read_ready", read_ready, 1'b0);
        check("rstw_resp_valid", resp_valid, 1'b0);
        check("rstw_count", timeout_count, 16'd0);
        check("rstw_read_select", read_select, 12'h000);
        step();
        reset_n = 1'b1;
        step();
        issue(12'h1D4);
        complete(64'hABCD_0123_4567_89EF);
        check("post_rst_valid", resp_valid, 1'b1);
        check("post_rst_data", resp_data, 64'hABCD_0123_4567_89EF);
        check("post_rst_select", resp_select, 12'h1D4);
        check("post_rst_timeout", resp_timeout, 1'b0);
        pop_one();
        check("post_rst_empty", resp_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/magic_device_requester.md
Name: magic_device_requester

Overview:
Initiator-side master for the magic device read interface (12-bit select, ready/valid, 64-bit data). It accepts read commands from a host-side ready/valid port, drives the device one command at a time, and bounds each wait with a timeout. Results (data or timeout) are buffered in a small response FIFO. It sits between the debug/testharness control logic and the magic device, replacing ad-hoc polling.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles read_ready is held per command before giving up (>=1)
RESP_DEPTH, 2, response FIFO entries (power of two, >=1)
STAT_W, 16, width of saturating timeout counter

Ports:
clock  input  1  sole clock, all state on posedge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  command valid
req_ready  output  1  command accepted when req_valid && req_ready
req_select  input  12  device register select
read_select  output  12  select driven to device; stable while read_ready=1
read_ready  output  1  requester waiting for data
read_valid  input  1  device data valid
read_data  input  64  device data, sampled when read_ready && read_valid
resp_valid  output  1  FIFO head valid
resp_ready  input  1  consumer pops head when resp_valid && resp_ready
resp_data  output  64  read data (0 on timeout)
resp_select  output  12  select of the completed command
resp_timeout  output  1  1 = command timed out
timeout_count  output  STAT_W  saturating count of timeouts

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, read_ready=0, read_select=0, FIFO empty, resp_valid=0, resp_* = 0, timeout_count=0, wait counter=0. Reset mid-WAIT abandons the command with no response.
- FSM states IDLE, WAIT.
- IDLE: req_ready = (fifo_count < RESP_DEPTH). On accept, register req_select into read_select, clear wait counter, go WAIT. read_ready is registered, so it rises the cycle after accept.
- WAIT: req_ready=0, read_ready=1, read_select held.
  - Transfer: read_ready && read_valid in the same cycle → push {timeout=0, select, read_data}, drop read_ready next cycle, go IDLE.
  - Otherwise, if wait counter == TIMEOUT_CYCLES-1 → push {timeout=1, select, data=0}, increment timeout_count (saturate at all-ones), go IDLE.
  - Otherwise increment wait counter.
  - read_valid in the expiry cycle: data wins, no timeout recorded.
- read_valid while read_ready=0 is ignored; no data is captured.
- read_ready stays high for at most TIMEOUT_CYCLES consecutive cycles.
- Only one command is outstanding. Because accept requires FIFO space and the FIFO only drains during WAIT, a push never hits a full FIFO.
- Latency:
  - Accept in cycle N → read_ready=1 in cycle N+1.
  - Transfer in cycle M → resp_valid=1 in cycle M+1.
  - Back-to-back: the next command can be accepted in cycle M+1 (IDLE), giving read_ready again in M+2.
- FIFO:
  - First-word-fall-through from registers; resp_* reflect the head.
  - Simultaneous push and pop when non-empty: count unchanged, order preserved.
  - Push into empty while popping: impossible, since resp_valid=0.
  - Pointer wrap is modulo RESP_DEPTH.
- resp_* hold stable while resp_valid && !resp_ready.

Decomposition:
- Package magic_dev_pkg:
  - SELECT_W=12, DATA_W=64
  - typedef resp_entry_t {timeout, select[11:0], data[63:0]} (77 bits)
  - enum req_state_e {IDLE, WAIT}
- Sub-module magic_dev_resp_fifo (parameterised depth and entry type): push/pop, count, FWFT head; reused by other host-side bridges.

Test Plan:
- Single read: req_select=0x012 accepted cycle 10; device read_valid=1 with read_data=0xDEADBEEF_CAFEF00D at cycle 13 → read_ready 1 in cycles 11–13; resp_valid at 14 with resp_data=0xDEADBEEF_CAFEF00D, resp_select=0x012, resp_timeout=0.
- Timeout: TIMEOUT_CYCLES=8, device silent → read_ready high exactly 8 cycles; response resp_timeout=1, resp_data=0, timeout_count=1; second silent command → timeout_count=2.
- Expiry race: read_valid asserted exactly on the 8th wait cycle with data 0x5 → resp_timeout=0, resp_data=0x5, timeout_count unchanged.
- Backpressure: RESP_DEPTH=2, resp_ready=0, issue 3 commands → two responses queued, req_ready=0 for the third, read_ready stays 0. Then resp_ready=1 for one cycle → third accepted, responses pop in select order.
- Spurious valid: read_valid=1 while IDLE → no FIFO push, resp_valid stays 0.
- Reset mid-WAIT: reset_n low during WAIT → read_ready drops immediately, FIFO empty, timeout_count=0; after release, a new command completes normally.
